// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch/execute/memory sequencer driving the program counter and AD_Bus
// Optional WAIT_TIMEOUT_EN: bounded FETCH/MEM waits with a one-cycle bus_error pulse.
module fetch_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        mem_ready,
  input  logic [31:0] data_in,
  input  logic        exec_done,
  input  logic [1:0]  mem_op,
  input  logic [31:0] mem_address,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_request,
  output logic        mem_write,
  output logic        pc_write,
  output logic        pc_jump,
  output logic        pc_use_offset,
  output logic        pc_address_in_to_AD,
  output logic [31:0] pc_address,
  output logic [31:0] instruction,
  output logic        instruction_valid,
  output logic [2:0]  state,
  output logic        bus_error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_ADVANCE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic        br_q, br_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q;
  logic        timeout;

  logic        mem_request_q, mem_write_q, pc_write_q, pc_jump_q;
  logic        pc_use_offset_q, pc_address_in_to_AD_q, instr_valid_q, bus_error_q;
  logic [31:0] pc_address_q;

`ifdef WAIT_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    br_d    = br_q;
    tgt_d   = tgt_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE:    if (!halt) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) state_d = S_EXECUTE;
`ifdef WAIT_TIMEOUT_EN
        else if (wait_cnt_q == 4'd14) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end
`endif
      end
      S_EXECUTE: begin
        if (exec_done) begin
          op_d    = mem_op;
          addr_d  = mem_address;
          br_d    = branch_taken;
          tgt_d   = branch_target;
          state_d = (mem_op == 2'b01 || mem_op == 2'b10) ? S_MEM : S_ADVANCE;
        end
      end
      S_MEM: begin
        if (mem_ready) state_d = S_ADVANCE;
`ifdef WAIT_TIMEOUT_EN
        else if (wait_cnt_q == 4'd14) begin
          timeout = 1'b1;
          state_d = S_ADVANCE;
        end
`endif
      end
      S_ADVANCE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

`ifdef WAIT_TIMEOUT_EN
  // Counts the 15th consecutive unanswered wait cycle as the timeout edge.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q)
      wait_cnt_d = 4'd0;
    else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready)
      wait_cnt_d = wait_cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wait_cnt_q <= 4'd0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q               <= S_IDLE;
      op_q                  <= 2'b00;
      addr_q                <= 32'd0;
      br_q                  <= 1'b0;
      tgt_q                 <= 32'd0;
      instr_q               <= 32'd0;
      mem_request_q         <= 1'b0;
      mem_write_q           <= 1'b0;
      pc_write_q            <= 1'b0;
      pc_jump_q             <= 1'b0;
      pc_use_offset_q       <= 1'b0;
      pc_address_in_to_AD_q <= 1'b0;
      pc_address_q          <= 32'd0;
      instr_valid_q         <= 1'b0;
      bus_error_q           <= 1'b0;
    end else begin
      state_q               <= state_d;
      op_q                  <= op_d;
      addr_q                <= addr_d;
      br_q                  <= br_d;
      tgt_q                 <= tgt_d;
      if (state_q == S_FETCH && mem_ready)
        instr_q <= data_in;
      mem_request_q         <= (state_d == S_FETCH) || (state_d == S_MEM);
      mem_write_q           <= (state_d == S_MEM) && (op_d == 2'b10);
      pc_write_q            <= (state_d == S_ADVANCE);
      pc_jump_q             <= (state_d == S_ADVANCE) && br_d;
      pc_use_offset_q       <= (state_d == S_MEM);
      pc_address_in_to_AD_q <= (state_d == S_MEM);
      if (state_d == S_MEM)
        pc_address_q <= addr_d;
      else if (state_d == S_ADVANCE && br_d)
        pc_address_q <= tgt_d;
      else
        pc_address_q <= 32'd0;
      instr_valid_q         <= (state_q == S_FETCH) && (state_d == S_EXECUTE);
      bus_error_q           <= timeout;
    end
  end

  assign mem_request         = mem_request_q;
  assign mem_write           = mem_write_q;
  assign pc_write            = pc_write_q;
  assign pc_jump             = pc_jump_q;
  assign pc_use_offset       = pc_use_offset_q;
  assign pc_address_in_to_AD = pc_address_in_to_AD_q;
  assign pc_address          = pc_address_q;
  assign instruction         = instr_q;
  assign instruction_valid   = instr_valid_q;
  assign state               = state_q;
  assign bus_error           = bus_error_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - table-driven bench for fetch_controller
module tb_fetch_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        halt, mem_ready, exec_done, branch_taken;
  logic [31:0] data_in, mem_address, branch_target;
  logic [1:0]  mem_op;
  logic        mem_request, mem_write, pc_write, pc_jump, pc_use_offset, pc_address_in_to_AD;
  logic [31:0] pc_address, instruction;
  logic        instruction_valid, bus_error;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  fetch_controller dut (
    .clock(clock), .reset(reset), .halt(halt), .mem_ready(mem_ready), .data_in(data_in),
    .exec_done(exec_done), .mem_op(mem_op), .mem_address(mem_address),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .mem_request(mem_request), .mem_write(mem_write), .pc_write(pc_write), .pc_jump(pc_jump),
    .pc_use_offset(pc_use_offset), .pc_address_in_to_AD(pc_address_in_to_AD),
    .pc_address(pc_address), .instruction(instruction), .instruction_valid(instruction_valid),
    .state(state), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        h, mr, ed;
    logic [1:0]  op;
    logic [31:0] addr;
    logic        br;
    logic [31:0] tgt, din;
    logic [2:0]  st;
    logic        mreq, mw, pw, pj, uo, ad;
    logic [31:0] pa, ins;
    logic        iv;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    logic ok_req, ok_err;
    // h mr ed op addr br tgt din | st mreq mw pw pj uo ad pa ins iv
    vecs[0]  = '{1,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd0,0,0,0,0,0,0,32'h0,32'h0,0};
    vecs[1]  = '{0,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd1,1,0,0,0,0,0,32'h0,32'h0,0};
    vecs[2]  = '{0,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd1,1,0,0,0,0,0,32'h0,32'h0,0};
    vecs[3]  = '{0,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd1,1,0,0,0,0,0,32'h0,32'h0,0};
    vecs[4]  = '{0,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd1,1,0,0,0,0,0,32'h0,32'h0,0};
    vecs[5]  = '{0,1,0,2'b00,32'h0,0,32'h0,32'h00A00093, 3'd2,0,0,0,0,0,0,32'h0,32'h00A00093,1};
    vecs[6]  = '{0,1,0,2'b00,32'h0,0,32'h0,32'h0,        3'd2,0,0,0,0,0,0,32'h0,32'h00A00093,0};
    vecs[7]  = '{0,0,1,2'b01,32'h11,0,32'h0,32'h0,       3'd3,1,0,0,0,1,1,32'h11,32'h00A00093,0};
    vecs[8]  = '{0,0,1,2'b10,32'hFFFF0000,1,32'h99,32'h0,3'd3,1,0,0,0,1,1,32'h11,32'h00A00093,0};
    vecs[9]  = '{0,1,0,2'b00,32'h0,0,32'h0,32'h0,        3'd4,0,0,1,0,0,0,32'h0,32'h00A00093,0};
    vecs[10] = '{0,1,1,2'b00,32'h0,0,32'h0,32'h0,        3'd0,0,0,0,0,0,0,32'h0,32'h00A00093,0};
    vecs[11] = '{0,1,1,2'b00,32'h0,0,32'h0,32'h0,        3'd1,1,0,0,0,0,0,32'h0,32'h00A00093,0};
    vecs[12] = '{0,1,0,2'b00,32'h0,0,32'h0,32'hDEADBEEF, 3'd2,0,0,0,0,0,0,32'h0,32'hDEADBEEF,1};
    vecs[13] = '{0,0,1,2'b10,32'h40,1,32'h20,32'h0,      3'd3,1,1,0,0,1,1,32'h40,32'hDEADBEEF,0};
    vecs[14] = '{0,1,0,2'b00,32'h0,0,32'h0,32'h0,        3'd4,0,0,1,1,0,0,32'h20,32'hDEADBEEF,0};
    vecs[15] = '{0,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd0,0,0,0,0,0,0,32'h0,32'hDEADBEEF,0};
    vecs[16] = '{0,1,0,2'b00,32'h0,0,32'h0,32'h0,        3'd1,1,0,0,0,0,0,32'h0,32'hDEADBEEF,0};
    vecs[17] = '{0,1,0,2'b00,32'h0,0,32'h0,32'h12345678, 3'd2,0,0,0,0,0,0,32'h0,32'h12345678,1};
    vecs[18] = '{0,0,1,2'b11,32'h55,0,32'h77,32'h0,      3'd4,0,0,1,0,0,0,32'h0,32'h12345678,0};
    vecs[19] = '{1,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd0,0,0,0,0,0,0,32'h0,32'h12345678,0};
    vecs[20] = '{1,0,0,2'b00,32'h0,0,32'h0,32'h0,        3'd0,0,0,0,0,0,0,32'h0,32'h12345678,0};

    reset = 1'b0; halt = 1'b1; mem_ready = 1'b0; exec_done = 1'b0; mem_op = 2'b00;
    mem_address = 32'h0; branch_taken = 1'b0; branch_target = 32'h0; data_in = 32'h0;
    step(); step();
    chk("reset_state", {29'd0, state}, 32'd0);
    chk("reset_strobes", {26'd0, mem_request, mem_write, pc_write, pc_jump, pc_use_offset, pc_address_in_to_AD}, 32'd0);
    chk("reset_instr", instruction, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) begin
      halt = vecs[i].h; mem_ready = vecs[i].mr; exec_done = vecs[i].ed; mem_op = vecs[i].op;
      mem_address = vecs[i].addr; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      data_in = vecs[i].din;
      step();
      chk($sformatf("v%0d_state", i), {29'd0, state}, {29'd0, vecs[i].st});
      chk($sformatf("v%0d_strobes", i),
          {26'd0, mem_request, mem_write, pc_write, pc_jump, pc_use_offset, pc_address_in_to_AD},
          {26'd0, vecs[i].mreq, vecs[i].mw, vecs[i].pw, vecs[i].pj, vecs[i].uo, vecs[i].ad});
      chk($sformatf("v%0d_pc_address", i), pc_address, vecs[i].pa);
      chk($sformatf("v%0d_instruction", i), instruction, vecs[i].ins);
      chk($sformatf("v%0d_ivalid", i), {31'd0, instruction_valid}, {31'd0, vecs[i].iv});
    end

    // Free-running loop: 1,2,4,0 repeating with pc_write only in ADVANCE.
    halt = 1'b0; mem_ready = 1'b1; exec_done = 1'b1; mem_op = 2'b00; branch_taken = 1'b0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] exp_st;
      case (i % 4)
        0: exp_st = 3'd1;
        1: exp_st = 3'd2;
        2: exp_st = 3'd4;
        default: exp_st = 3'd0;
      endcase
      step();
      chk($sformatf("loop%0d_state", i), {29'd0, state}, {29'd0, exp_st});
      chk($sformatf("loop%0d_pcw_pj", i), {30'd0, pc_write, pc_jump}, {30'd0, (exp_st == 3'd4), 1'b0});
    end

    // Asynchronous reset in the middle of a load.
    mem_op = 2'b01; mem_address = 32'h11;
    step(); step();
    mem_ready = 1'b0;
    step();
    chk("mid_mem_state", {29'd0, state}, 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_state", {29'd0, state}, 32'd0);
    chk("async_rst_strobes", {26'd0, mem_request, mem_write, pc_write, pc_jump, pc_use_offset, pc_address_in_to_AD}, 32'd0);
    chk("async_rst_pc_address", pc_address, 32'd0);
    chk("async_rst_instr", instruction, 32'd0);
    #2 reset = 1'b1;
    step();
    chk("restart_fetch", {29'd0, state, mem_request}, 32'd3);

`ifdef WAIT_TIMEOUT_EN
    n = 1;
    ok_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_error) begin
        ok_err = 1'b1;
        break;
      end
      if (mem_request && state == 3'd1) n++;
    end
    chk("timeout_seen", {31'd0, ok_err}, 32'd1);
    chk("timeout_fetch_cycles", n, 32'd15);
    chk("timeout_idle", {29'd0, state, mem_request}, 32'd0);
    step();
    chk("timeout_retry", {29'd0, state, bus_error}, 32'd2);
`else
    ok_req = 1'b1; ok_err = 1'b1; n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!mem_request || state != 3'd1) ok_req = 1'b0;
      if (bus_error) ok_err = 1'b0;
    end
    chk("no_timeout_request", {31'd0, ok_req}, 32'd1);
    chk("no_timeout_bus_error", {31'd0, ok_err}, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
